// File: rtl/ram1p1rwbe_clr_pkg.sv
// ram1p1rwbe_clr_pkg: shared types for the byte-enable RAM and its zero-fill sequencer
package ram1p1rwbe_clr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: zero-fill sequencer walking every RAM address once per clear
module ram_clear_seq
    import ram1p1rwbe_clr_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] waddr,
    output logic                     wen
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    clr_state_e    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    // next state: the end test is an explicit compare with the last address, never the wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (clear) begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
        busy  = (state_q == ST_CLEAR);
        wen   = busy;
        waddr = cnt_q;
    end

    // state register; a reset mid-fill restarts it from address 0 or abandons it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ram1p1rwbe_clr.sv
// ram1p1rwbe_clr: single-port byte-write-enable RAM with zero-fill, collision mode and optional output register
module ram1p1rwbe_clr
    import ram1p1rwbe_clr_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int WIDTH          = 44,
    parameter int OUTREG         = 0,
    parameter int WRITE_FIRST    = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    input  logic                     we,
    input  logic [(WIDTH-1)/8:0]     bwe,
    input  logic                     clear,
    output logic                     busy,
    output logic [WIDTH-1:0]         dout,
    output logic                     dvalid
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LANES = (WIDTH - 1) / 8 + 1;
    localparam int MSBW  = WIDTH % 8;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mask, old_word, merged, wdata_d, rd1_d, rd1_q;
    logic [AW-1:0]    waddr_d, seq_addr;
    logic             wen_d, seq_wen, seq_busy, acc, v1_d, v1_q;

    // expand lane enables to a bit mask; the top lane is narrower when WIDTH is not a byte multiple
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam int LW = (l == LANES - 1 && MSBW != 0) ? MSBW : 8;
        assign mask[l*8 +: LW] = {LW{bwe[l]}};
    end

    ram_clear_seq #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_seq (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .busy    (seq_busy),
        .waddr   (seq_addr),
        .wen     (seq_wen)
    );

    assign busy = seq_busy;

    // port/sequencer mux: the sequencer owns the array while busy, port accesses are dropped
    always_comb begin
        acc      = ce & ~seq_busy;
        old_word = mem_q[addr];
        merged   = (old_word & ~mask) | (din & mask);
        wen_d    = seq_wen | (acc & we);
        waddr_d  = seq_wen ? seq_addr : addr;
        wdata_d  = seq_wen ? '0 : merged;
        rd1_d    = acc ? ((WRITE_FIRST != 0 && we) ? merged : old_word) : rd1_q;
        v1_d     = acc;
    end

    // array storage, deliberately not touched by reset_n
    always_ff @(posedge clk) begin
        if (wen_d) mem_q[waddr_d] <= wdata_d;
    end

    // first read stage: data holds when idle, only the valid drops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd1_q <= '0;
            v1_q  <= 1'b0;
        end else begin
            rd1_q <= rd1_d;
            v1_q  <= v1_d;
        end
    end

    if (OUTREG != 0) begin : g_outreg
        logic [WIDTH-1:0] rd2_q, rd2_d;
        logic             v2_q;

        assign rd2_d = v1_q ? rd1_q : rd2_q;

        // optional second stage adds one cycle of read latency
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd2_q <= '0;
                v2_q  <= 1'b0;
            end else begin
                rd2_q <= rd2_d;
                v2_q  <= v1_q;
            end
        end

        assign dout   = rd2_q;
        assign dvalid = v2_q;
    end else begin : g_direct
        assign dout   = rd1_q;
        assign dvalid = v1_q;
    end

endmodule

// File: tb/tb_ram1p1rwbe_clr.sv
// tb_ram1p1rwbe_clr: directed self-checking bench across three RAM configurations
module tb_ram1p1rwbe_clr;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // u0: DEPTH 64, WIDTH 44, read-first, no output register, clear on reset
    logic        ce0 = 0, we0 = 0, clr0 = 0, busy0, dv0;
    logic [5:0]  addr0 = '0;
    logic [43:0] din0 = '0, dout0;
    logic [5:0]  bwe0 = '0;

    // u1: DEPTH 16, WIDTH 22, write-first, output register, clear on reset
    logic        ce1 = 0, we1 = 0, clr1 = 0, busy1, dv1;
    logic [3:0]  addr1 = '0;
    logic [21:0] din1 = '0, dout1;
    logic [2:0]  bwe1 = '0;

    // u2: DEPTH 8, WIDTH 8, read-first, no output register, no clear on reset
    logic        ce2 = 0, we2 = 0, clr2 = 0, busy2, dv2;
    logic [2:0]  addr2 = '0;
    logic [7:0]  din2 = '0, dout2;
    logic [0:0]  bwe2 = '0;

    ram1p1rwbe_clr #(.DEPTH(64), .WIDTH(44), .OUTREG(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .reset_n(reset_n), .ce(ce0), .addr(addr0), .din(din0), .we(we0),
        .bwe(bwe0), .clear(clr0), .busy(busy0), .dout(dout0), .dvalid(dv0));

    ram1p1rwbe_clr #(.DEPTH(16), .WIDTH(22), .OUTREG(1), .WRITE_FIRST(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset_n(reset_n), .ce(ce1), .addr(addr1), .din(din1), .we(we1),
        .bwe(bwe1), .clear(clr1), .busy(busy1), .dout(dout1), .dvalid(dv1));

    ram1p1rwbe_clr #(.DEPTH(8), .WIDTH(8), .OUTREG(0), .WRITE_FIRST(0), .CLEAR_ON_RESET(0)) u2 (
        .clk(clk), .reset_n(reset_n), .ce(ce2), .addr(addr2), .din(din2), .we(we2),
        .bwe(bwe2), .clear(clr2), .busy(busy2), .dout(dout2), .dvalid(dv2));

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (dout0 !== 44'h0 || dv0 !== 1'b0) begin errors++; $display("FAIL reset_u0_out dout=%h dvalid=%b want 0/0", dout0, dv0); end
        checks++; if (dout1 !== 22'h0 || dv1 !== 1'b0) begin errors++; $display("FAIL reset_u1_out dout=%h dvalid=%b want 0/0", dout1, dv1); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL reset_busy_u0 got %b want 1", busy0); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy_u2 got %b want 0", busy2); end
        reset_n = 1'b1;
        begin
            int n = 0;
            while (busy0 && n < 200) begin n++; @(negedge clk); end
            checks++; if (n !== 64) begin errors++; $display("FAIL fill_len_reset got %0d want 64", n); end
        end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL u2_busy_after_reset got %b want 0", busy2); end
    endtask

    task automatic test_read_cleared();
        for (int a = 0; a < 64; a++) begin
            ce0 = 1'b1; we0 = 1'b0; addr0 = 6'(a);
            @(negedge clk);
            checks++; if (dout0 !== 44'h0 || dv0 !== 1'b1) begin errors++; $display("FAIL cleared_rd[%0d] dout=%h dvalid=%b want 0/1", a, dout0, dv0); end
        end
        ce0 = 1'b0;
        @(negedge clk);
        checks++; if (dv0 !== 1'b0) begin errors++; $display("FAIL cleared_idle_dvalid got %b want 0", dv0); end
    endtask

    task automatic test_partial_lane();
        ce1 = 1'b1; we1 = 1'b1; addr1 = 4'd5; din1 = 22'h3FFFFF; bwe1 = 3'b101;
        @(negedge clk);
        we1 = 1'b0;
        @(negedge clk);
        ce1 = 1'b0;
        checks++; if (dout1 !== 22'h3F00FF || dv1 !== 1'b1) begin errors++; $display("FAIL lane_write_wf dout=%h dvalid=%b want 3f00ff/1", dout1, dv1); end
        @(negedge clk);
        checks++; if (dout1 !== 22'h3F00FF || dv1 !== 1'b1) begin errors++; $display("FAIL lane_read dout=%h dvalid=%b want 3f00ff/1", dout1, dv1); end
        @(negedge clk);
        checks++; if (dv1 !== 1'b0 || dout1 !== 22'h3F00FF) begin errors++; $display("FAIL lane_hold dout=%h dvalid=%b want 3f00ff/0", dout1, dv1); end
    endtask

    task automatic test_collision();
        ce0 = 1'b1; we0 = 1'b1; addr0 = 6'd7; din0 = {44{1'b1}}; bwe0 = 6'h3F;
        ce1 = 1'b1; we1 = 1'b1; addr1 = 4'd7; din1 = {22{1'b1}}; bwe1 = 3'h7;
        @(negedge clk);
        ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; we1 = 1'b0;
        checks++; if (dout0 !== 44'h0 || dv0 !== 1'b1) begin errors++; $display("FAIL read_first dout=%h dvalid=%b want 0/1", dout0, dv0); end
        @(negedge clk);
        checks++; if (dout1 !== 22'h3FFFFF || dv1 !== 1'b1) begin errors++; $display("FAIL write_first dout=%h dvalid=%b want 3fffff/1", dout1, dv1); end
        ce0 = 1'b1; addr0 = 6'd7;
        @(negedge clk);
        ce0 = 1'b0;
        checks++; if (dout0 !== 44'hFFFFFFFFFFF) begin errors++; $display("FAIL read_first_stored got %h want fffffffffff", dout0); end
    endtask

    task automatic test_back_to_back();
        for (int a = 1; a <= 3; a++) begin
            ce1 = 1'b1; we1 = 1'b1; addr1 = 4'(a); din1 = 22'(a * 22'h11111); bwe1 = 3'h7;
            @(negedge clk);
        end
        ce1 = 1'b0; we1 = 1'b0;
        repeat (3) @(negedge clk);
        ce1 = 1'b1; addr1 = 4'd1;
        @(negedge clk);
        checks++; if (dv1 !== 1'b0) begin errors++; $display("FAIL b2b_c1 dvalid=%b want 0", dv1); end
        addr1 = 4'd2;
        @(negedge clk);
        checks++; if (dout1 !== 22'h11111 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_c2 dout=%h dvalid=%b want 11111/1", dout1, dv1); end
        addr1 = 4'd3;
        @(negedge clk);
        checks++; if (dout1 !== 22'h22222 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_c3 dout=%h dvalid=%b want 22222/1", dout1, dv1); end
        ce1 = 1'b0;
        @(negedge clk);
        checks++; if (dout1 !== 22'h33333 || dv1 !== 1'b1) begin errors++; $display("FAIL b2b_c4 dout=%h dvalid=%b want 33333/1", dout1, dv1); end
        @(negedge clk);
        checks++; if (dout1 !== 22'h33333 || dv1 !== 1'b0) begin errors++; $display("FAIL b2b_hold dout=%h dvalid=%b want 33333/0", dout1, dv1); end
    endtask

    task automatic test_clear_during_fill();
        int n = 0;
        int bad = 0;
        ce0 = 1'b1; we0 = 1'b0; addr0 = 6'd7; clr0 = 1'b1;
        @(negedge clk);
        ce0 = 1'b0; clr0 = 1'b0;
        checks++; if (dout0 !== 44'hFFFFFFFFFFF || dv0 !== 1'b1) begin errors++; $display("FAIL ce_with_clear dout=%h dvalid=%b want fffffffffff/1", dout0, dv0); end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL clear_start_busy got %b want 1", busy0); end
        while (busy0 && n < 200) begin
            if (n == 5) begin
                ce0 = 1'b1; we0 = 1'b1; addr0 = 6'd3; din0 = {44{1'b1}}; bwe0 = 6'h3F; clr0 = 1'b1;
            end else begin
                ce0 = 1'b0; we0 = 1'b0; clr0 = 1'b0;
            end
            n++;
            @(negedge clk);
            if (dv0) bad++;
        end
        ce0 = 1'b0; we0 = 1'b0; clr0 = 1'b0;
        checks++; if (n !== 64) begin errors++; $display("FAIL fill_len_cmd got %0d want 64", n); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL dvalid_during_fill got %0d want 0", bad); end
        ce0 = 1'b1; addr0 = 6'd3;
        @(negedge clk);
        addr0 = 6'd7;
        checks++; if (dout0 !== 44'h0 || dv0 !== 1'b1) begin errors++; $display("FAIL dropped_write dout=%h dvalid=%b want 0/1", dout0, dv0); end
        @(negedge clk);
        ce0 = 1'b0;
        checks++; if (dout0 !== 44'h0) begin errors++; $display("FAIL refilled_addr7 got %h want 0", dout0); end
    endtask

    task automatic test_clear_cmd();
        int n = 0;
        ce2 = 1'b1; we2 = 1'b1; addr2 = 3'd2; din2 = 8'hAA; bwe2 = 1'b1; clr2 = 1'b1;
        @(negedge clk);
        ce2 = 1'b0; we2 = 1'b0; clr2 = 1'b0;
        checks++; if (dv2 !== 1'b1 || busy2 !== 1'b1) begin errors++; $display("FAIL u2_accept_with_clear dvalid=%b busy=%b want 1/1", dv2, busy2); end
        while (busy2 && n < 200) begin n++; @(negedge clk); end
        checks++; if (n !== 8) begin errors++; $display("FAIL u2_fill_len got %0d want 8", n); end
        ce2 = 1'b1; addr2 = 3'd2;
        @(negedge clk);
        ce2 = 1'b0;
        checks++; if (dout2 !== 8'h00 || dv2 !== 1'b1) begin errors++; $display("FAIL u2_cleared dout=%h dvalid=%b want 00/1", dout2, dv2); end
    endtask

    task automatic test_reset_mid_fill();
        int n = 0;
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        while (n < 20) begin
            clr2 = (n == 17);
            n++;
            @(negedge clk);
        end
        clr2 = 1'b0;
        checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL u2_midfill_busy got %b want 1", busy2); end
        reset_n = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_u0 got %b want 1", busy0); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon_u2 got %b want 0", busy2); end
        checks++; if (dout1 !== 22'h0 || dv1 !== 1'b0) begin errors++; $display("FAIL rst_mid_u1_out dout=%h dvalid=%b want 0/0", dout1, dv1); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        while (busy0 && n < 200) begin n++; @(negedge clk); end
        checks++; if (n !== 64) begin errors++; $display("FAIL fill_len_restart got %0d want 64", n); end
        checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL u2_idle_after_reset got %b want 0", busy2); end
    endtask

    initial begin
        test_reset();
        test_read_cleared();
        test_partial_lane();
        test_collision();
        test_back_to_back();
        test_clear_during_fill();
        test_clear_cmd();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
